// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code set 2 sequencer: prefix FSM with watchdog, held-key bitmap, event FIFO.
// Events are written on the edge that samples the completing byte; a full FIFO drops and sets a sticky flag.
module ps2_key_ctrl #(
  parameter int EVT_DEPTH = 4,
  parameter int TMO_CYC   = 25000
) (
  input  logic        clk25,
  input  logic        clr,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_err,
  output logic [10:0] key_held,
  output logic        evt_valid,
  output logic [9:0]  evt_data,
  input  logic        evt_pop,
  output logic        evt_ovf,
  output logic        seq_busy
);

  localparam int AW = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          busy_q;
  logic [10:0]   held_q, held_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic [9:0]    mem_q [EVT_DEPTH];

  logic          ev_go, ev_make, ev_ext;
  logic          map_hit;
  logic [3:0]    map_idx;
  logic          push, pop_eff, full, wr_ok, drop;
  logic [9:0]    ev_dat;

  // Prefix decoder; rx_err overrides any byte arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    ev_go   = 1'b0;
    ev_make = 1'b0;
    ev_ext  = 1'b0;
    if (rx_err) begin
      state_d = S_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == 8'hE0)      state_d = S_EXT;
          else if (rx_data == 8'hF0) state_d = S_BRK;
          else if (!(rx_data inside {8'h00, 8'hFF, 8'hFA, 8'hAA, 8'hEE, 8'hFE})) begin
            ev_go   = 1'b1;
            ev_make = 1'b1;
          end
        end
        S_EXT: begin
          if (rx_data == 8'hF0)      state_d = S_EXT_BRK;
          else if (rx_data == 8'hE0) state_d = S_EXT;
          else begin
            ev_go   = 1'b1;
            ev_make = 1'b1;
            ev_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          if (rx_data == 8'hE0)      state_d = S_EXT;
          else if (rx_data == 8'hF0) state_d = S_BRK;
          else begin
            ev_go   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: begin
          if (rx_data == 8'hE0)      state_d = S_EXT;
          else if (rx_data == 8'hF0) state_d = S_EXT_BRK;
          else begin
            ev_go   = 1'b1;
            ev_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
      endcase
    end else if (state_q != S_IDLE && wdog_q == WW'(TMO_CYC - 1)) begin
      state_d = S_IDLE;
    end
    wdog_d = (rx_valid || rx_err || state_d == S_IDLE) ? '0 : wdog_q + WW'(1);
  end

  always_comb begin
    map_hit = 1'b1;
    map_idx = 4'd0;
    case ({ev_ext, rx_data})
      9'h01D:  map_idx = 4'd0;
      9'h01C:  map_idx = 4'd1;
      9'h01B:  map_idx = 4'd2;
      9'h023:  map_idx = 4'd3;
      9'h175:  map_idx = 4'd4;
      9'h16B:  map_idx = 4'd5;
      9'h172:  map_idx = 4'd6;
      9'h174:  map_idx = 4'd7;
      9'h029:  map_idx = 4'd8;
      9'h05A:  map_idx = 4'd9;
      9'h076:  map_idx = 4'd10;
      default: map_hit = 1'b0;
    endcase
  end

  // Mapped keys only emit on a state change, which filters typematic repeats.
  always_comb begin
    held_d = held_q;
    push   = 1'b0;
    if (ev_go) begin
      if (map_hit) begin
        if (held_q[map_idx] != ev_make) begin
          push            = 1'b1;
          held_d[map_idx] = ev_make;
        end
      end else begin
        push = 1'b1;
      end
    end
  end

  assign ev_dat  = {ev_make, ev_ext, rx_data};
  assign pop_eff = evt_pop && (cnt_q != '0);
  assign full    = (cnt_q == CW'(EVT_DEPTH));
  assign wr_ok   = push && (!full || pop_eff);
  assign drop    = push && full && !pop_eff;

  always_ff @(posedge clk25 or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      wdog_q   <= '0;
      busy_q   <= 1'b0;
      held_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      busy_q  <= (state_d != S_IDLE);
      held_q  <= held_d;
      if (wr_ok)   wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_eff) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(wr_ok) - CW'(pop_eff);
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: the read side is masked while the FIFO is empty.
  always_ff @(posedge clk25) begin
    if (wr_ok) mem_q[wr_ptr_q] <= ev_dat;
  end

  assign key_held  = held_q;
  assign evt_valid = (cnt_q != '0);
  assign evt_data  = (cnt_q != '0) ? mem_q[rd_ptr_q] : 10'h000;
  assign evt_ovf   = ovf_q;
  assign seq_busy  = busy_q;

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
Sequences the decoded PS/2 keyboard byte stream into game-level key state. It sits between the PS/2 byte receiver and the game logic, both on clk25. It runs the scan-code set 2 prefix state machine (E0 extended, F0 break), keeps a held-key bitmap for the game control keys, and queues press/release events in a small FIFO with a valid/pop handshake. A prefix watchdog and error abort keep it from wedging on a corrupted stream.

Parameters:
EVT_DEPTH, 4, event FIFO depth in entries; power of two, 2..16.
TMO_CYC, 25000, clk25 cycles allowed between a prefix byte and the next byte (1 ms at 25 MHz).

Ports:
clk25  input  1  system clock, 25 MHz; the only clock.
clr  input  1  asynchronous active-high reset.
rx_valid  input  1  one-cycle strobe: rx_data holds a complete received byte.
rx_data  input  8  received scan-code byte.
rx_err  input  1  one-cycle strobe: frame error (parity/stop) in the receiver.
key_held  output  11  held bitmap: [0]W [1]A [2]S [3]D [4]Up [5]Left [6]Down [7]Right [8]Space [9]Enter [10]Esc.
evt_valid  output  1  FIFO not empty.
evt_data  output  10  head event {make, ext, code[7:0]}; make=1 press, 0 release.
evt_pop  input  1  consume the head event; ignored when evt_valid=0.
evt_ovf  output  1  sticky: at least one event was dropped because the FIFO was full.
seq_busy  output  1  1 while in a prefix state (not IDLE).

Behaviour:
- Reset (clr=1, async): state=IDLE, watchdog=0, key_held=0, FIFO empty, evt_valid=0, evt_data=0, evt_ovf=0, seq_busy=0.
- Decoder FSM states: IDLE, EXT (saw E0), BRK (saw F0), EXT_BRK (saw E0 F0). It advances only on cycles with rx_valid=1.
  - IDLE: E0->EXT; F0->BRK; 00/FF/FA/AA/EE/FE->IDLE with no event; any other byte produces make event (ext=0, code) and stays in IDLE.
  - EXT: F0->EXT_BRK; E0->EXT (restart); any other byte produces make event (ext=1) and returns to IDLE.
  - BRK: E0->EXT (restart, no event); F0->BRK; any other byte produces break event (ext=0) and returns to IDLE.
  - EXT_BRK: E0->EXT; F0->EXT_BRK; any other byte produces break event (ext=1) and returns to IDLE.
- rx_err=1 in any state: go to IDLE, produce no event. This applies even if rx_valid=1 in the same cycle; rx_err wins.
- Watchdog:
  - Counter clears on every rx_valid and increments each cycle in a non-IDLE state.
  - When it reaches TMO_CYC-1 with no byte arriving, the FSM goes to IDLE with no event.
  - Held in IDLE at 0.
- Key map:
  - Non-extended: 1D->W, 1C->A, 1B->S, 23->D, 29->Space, 5A->Enter, 76->Esc.
  - Extended: 75->Up, 6B->Left, 72->Down, 74->Right.
  - Extended 1D/1C etc. do NOT map to letters.
- Mapped keys: make sets the bit and break clears it. An event is pushed only if the bit changes, so typematic repeats and spurious breaks are filtered.
- Unmapped keys: every make/break pushes an event and leaves key_held unchanged.
- Timing:
  - key_held and the FIFO write occur on the clk25 edge that samples the completing rx_valid.
  - An event into an empty FIFO shows evt_valid=1 and evt_data on the following cycle.
  - No combinational path from rx_* to outputs.
- FIFO:
  - evt_data always shows the head entry, or 0 when empty.
  - evt_pop with evt_valid=1 removes the head at the clock edge.
  - Full with no pop: a new event is dropped, evt_ovf<=1, and key_held still updates.
  - Full with pop and push in the same cycle: both take effect, the count is unchanged, and nothing is dropped.
  - Empty with push and pop in the same cycle: the pop is ignored and the push is stored.
- evt_ovf clears only on clr.
- seq_busy = (state != IDLE), registered.
- Pointers wrap modulo EVT_DEPTH. Count width is log2(EVT_DEPTH)+1.

Test Plan:
- Reset, then bytes 1D; F0 1D, no pop -> after 1D: key_held=0x001, evt_data=0x21D. FIFO holds {0x21D, 0x01D}. Finally key_held=0x000.
- Bytes E0 75; E0 F0 75 -> key_held[4] rises then falls. Events 0x375 then 0x175. Bytes E0 1D -> event 0x31D with key_held unchanged.
- Bytes 1D,1D,1D (repeats) -> one event only. Byte 15 (Q) twice -> two events 0x215. Byte AA in IDLE -> no event.
- Bytes F0 then no byte for TMO_CYC cycles, then 1C -> seq_busy drops at timeout, and the 1C make sets key_held[1].
- Bytes F0, rx_err, 1D -> make event 0x21D, not a release.
- With EVT_DEPTH=4, push 5 unmapped makes without pop -> 4 entries and evt_ovf=1. Then pop while pushing a 6th -> count stays 4 and evt_ovf stays 1. Assert clr mid-prefix -> all outputs return to 0.
